// File: rtl/vc_sram_1r1w_pipelined.sv
// 1-read/1-write SRAM with byte enables, val/rdy read ports and a credit-protected response buffer.
// Optional macro VC_SRAM_CLEAR_EN zeroes the array word-by-word after every reset.
`timescale 1ns/1ps

module vc_sram_1r1w_pipelined #(
  parameter int unsigned p_data_nbits  = 32,
  parameter int unsigned p_num_entries = 256,
  parameter int unsigned p_read_lat    = 1,
  parameter int unsigned p_tag_nbits   = 4,
  parameter int unsigned p_rdw_new     = 1,
  localparam int unsigned c_data_nbytes = (p_data_nbits + 7) / 8,
  localparam int unsigned c_addr_nbits  = (p_num_entries > 1) ? $clog2(p_num_entries) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_req_val,
  output logic                     rd_req_rdy,
  input  logic [c_addr_nbits-1:0]  rd_req_addr,
  input  logic [p_tag_nbits-1:0]   rd_req_tag,
  output logic                     rd_rsp_val,
  input  logic                     rd_rsp_rdy,
  output logic [p_data_nbits-1:0]  rd_rsp_data,
  output logic [p_tag_nbits-1:0]   rd_rsp_tag,
  input  logic                     wr_val,
  output logic                     wr_rdy,
  input  logic [c_addr_nbits-1:0]  wr_addr,
  input  logic [c_data_nbytes-1:0] wr_byte_en,
  input  logic [p_data_nbits-1:0]  wr_data
);

  localparam int unsigned c_cnt_nbits = $clog2(p_read_lat + 1);
  localparam int unsigned c_occ_nbits = c_cnt_nbits + 1;
  localparam int unsigned c_ptr_nbits = (p_read_lat > 1) ? $clog2(p_read_lat) : 1;
  localparam int unsigned c_buf_depth = 1 << c_ptr_nbits;
  localparam int unsigned c_rsp_nbits = p_tag_nbits + p_data_nbits;

  logic [p_data_nbits-1:0] mem [p_num_entries];

  logic                    active;
  logic                    rd_fire;
  logic                    wr_fire;
  logic                    rsp_fire;
  logic [c_cnt_nbits-1:0]  in_flight;
  logic [c_cnt_nbits-1:0]  buf_count;
  logic [c_occ_nbits-1:0]  occupancy;
  logic [p_data_nbits-1:0] wr_mask;
  logic [p_data_nbits-1:0] rd_word;
  logic                    push_val;
  logic [c_rsp_nbits-1:0]  push_rsp;

  logic                    mem_we;
  logic [c_addr_nbits-1:0] mem_waddr;
  logic [p_data_nbits-1:0] mem_wmask;
  logic [p_data_nbits-1:0] mem_wdata;

  // Credit: a request is accepted only if its response is guaranteed a buffer slot
  assign occupancy  = c_occ_nbits'(in_flight) + c_occ_nbits'(buf_count);
  assign rsp_fire   = rd_rsp_val & rd_rsp_rdy;
  assign rd_req_rdy = active & ((occupancy < c_occ_nbits'(p_read_lat)) | rsp_fire);
  assign wr_rdy     = active;
  assign rd_fire    = rd_req_val & rd_req_rdy;
  assign wr_fire    = wr_val & wr_rdy;

  always_comb begin
    wr_mask = '0;
    for (int unsigned b = 0; b < p_data_nbits; b++) wr_mask[b] = wr_byte_en[b / 8];
  end

`ifdef VC_SRAM_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [c_addr_nbits-1:0] clear_addr;
  logic                    clearing;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_CLEAR;
      clear_addr <= '0;
    end else begin
      state <= state_next;
      if (state == ST_CLEAR) clear_addr <= c_addr_nbits'(clear_addr + 1'b1);
    end
  end

  always_comb begin
    state_next = state;
    if (state == ST_CLEAR && clear_addr == c_addr_nbits'(p_num_entries - 1)) state_next = ST_READY;
  end

  always_comb begin
    active   = 1'b0;
    clearing = 1'b0;
    case (state)
      ST_CLEAR: clearing = 1'b1;
      ST_READY: active   = 1'b1;
      default:  active   = 1'b0;
    endcase
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) active <= 1'b0;
    else        active <= 1'b1;
  end
`endif

  // Write port: a write coinciding with reset is dropped
  always_comb begin
    mem_we    = wr_fire & reset;
    mem_waddr = wr_addr;
    mem_wmask = wr_mask;
    mem_wdata = wr_data;
`ifdef VC_SRAM_CLEAR_EN
    if (clearing) begin
      mem_we    = reset;
      mem_waddr = clear_addr;
      mem_wmask = '1;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
  end

  // Asynchronous array read with optional same-cycle write forwarding
  always_comb begin
    rd_word = mem[rd_req_addr];
    if (p_rdw_new != 0 && wr_fire && wr_addr == rd_req_addr)
      rd_word = (rd_word & ~wr_mask) | (wr_data & wr_mask);
  end

  if (p_read_lat == 1) begin : g_nopipe
    assign push_val  = rd_fire;
    assign push_rsp  = {rd_req_tag, rd_word};
    assign in_flight = '0;
  end else begin : g_pipe
    logic                   pv [p_read_lat-1];
    logic [c_rsp_nbits-1:0] pd [p_read_lat-1];

    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int unsigned i = 0; i < p_read_lat - 1; i++) pv[i] <= 1'b0;
      end else begin
        pv[0] <= rd_fire;
        for (int unsigned i = 1; i < p_read_lat - 1; i++) pv[i] <= pv[i-1];
      end
    end

    always_ff @(posedge clk) begin
      pd[0] <= {rd_req_tag, rd_word};
      for (int unsigned i = 1; i < p_read_lat - 1; i++) pd[i] <= pd[i-1];
    end

    always_comb begin
      in_flight = '0;
      for (int unsigned i = 0; i < p_read_lat - 1; i++)
        if (pv[i]) in_flight = c_cnt_nbits'(in_flight + 1'b1);
    end

    assign push_val = pv[p_read_lat-2];
    assign push_rsp = pd[p_read_lat-2];
  end

  // Response FIFO; storage rounded up to a power of two, occupancy bounded by credits
  logic [c_rsp_nbits-1:0] rbuf [c_buf_depth];
  logic [c_ptr_nbits-1:0] wptr;
  logic [c_ptr_nbits-1:0] rptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr      <= '0;
      rptr      <= '0;
      buf_count <= '0;
    end else begin
      if (push_val) wptr <= c_ptr_nbits'(wptr + 1'b1);
      if (rsp_fire) rptr <= c_ptr_nbits'(rptr + 1'b1);
      case ({push_val, rsp_fire})
        2'b10:   buf_count <= c_cnt_nbits'(buf_count + 1'b1);
        2'b01:   buf_count <= c_cnt_nbits'(buf_count - 1'b1);
        default: buf_count <= buf_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_val) rbuf[wptr] <= push_rsp;
  end

  assign rd_rsp_val                = (buf_count != '0);
  assign {rd_rsp_tag, rd_rsp_data} = rbuf[rptr];

  a_ctrl_known: assert property (@(posedge clk) disable iff (!reset)
    !$isunknown({rd_req_val, wr_val, rd_rsp_rdy}));
  a_rd_addr: assert property (@(posedge clk) disable iff (!reset)
    rd_fire |-> (!$isunknown(rd_req_addr) && (32'(rd_req_addr) < p_num_entries)));
  a_wr_addr: assert property (@(posedge clk) disable iff (!reset)
    wr_fire |-> (!$isunknown(wr_addr) && (32'(wr_addr) < p_num_entries) && !$isunknown(wr_byte_en)));
  a_read_lat: assert property (@(posedge clk) disable iff (!reset)
    (p_read_lat >= 1 && p_read_lat <= 4));

endmodule

// File: tb/tb_vc_sram_1r1w_pipelined.sv
// Scoreboard bench for vc_sram_1r1w_pipelined: reference memory model plus in-order response queue.
`timescale 1ns/1ps

module tb_vc_sram_1r1w_pipelined;

  localparam int unsigned DW      = 32;
  localparam int unsigned NE      = 16;
  localparam int unsigned LAT     = 3;
  localparam int unsigned TW      = 4;
  localparam int unsigned RDW_NEW = 1;
  localparam int unsigned AW      = 4;
  localparam int unsigned NB      = 4;

  logic          clk;
  logic          reset;
  logic          rd_req_val;
  logic          rd_req_rdy;
  logic [AW-1:0] rd_req_addr;
  logic [TW-1:0] rd_req_tag;
  logic          rd_rsp_val;
  logic          rd_rsp_rdy;
  logic [DW-1:0] rd_rsp_data;
  logic [TW-1:0] rd_rsp_tag;
  logic          wr_val;
  logic          wr_rdy;
  logic [AW-1:0] wr_addr;
  logic [NB-1:0] wr_byte_en;
  logic [DW-1:0] wr_data;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  exp_t          sb [$];
  logic [DW-1:0] model [NE];
  int            n_tests;
  int            n_fail;
  int            cyc;
  bit            chk_lat;
  bit            last_rd_fire;
  bit            rsp_seen;

  vc_sram_1r1w_pipelined #(
    .p_data_nbits (DW),
    .p_num_entries(NE),
    .p_read_lat   (LAT),
    .p_tag_nbits  (TW),
    .p_rdw_new    (RDW_NEW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_req_val (rd_req_val),
    .rd_req_rdy (rd_req_rdy),
    .rd_req_addr(rd_req_addr),
    .rd_req_tag (rd_req_tag),
    .rd_rsp_val (rd_rsp_val),
    .rd_rsp_rdy (rd_rsp_rdy),
    .rd_rsp_data(rd_rsp_data),
    .rd_rsp_tag (rd_rsp_tag),
    .wr_val     (wr_val),
    .wr_rdy     (wr_rdy),
    .wr_addr    (wr_addr),
    .wr_byte_en (wr_byte_en),
    .wr_data    (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < NB; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  // One clock cycle: settle, observe handshakes, update model/scoreboard, advance to next negedge
  task automatic step();
    exp_t          e;
    bit            rsp_f;
    bit            rd_f;
    bit            wr_f;
    logic [DW-1:0] rexp;
    #1;
    rsp_f = (rd_rsp_val === 1'b1) && (rd_rsp_rdy === 1'b1);
    rd_f  = (rd_req_val === 1'b1) && (rd_req_rdy === 1'b1);
    wr_f  = (wr_val === 1'b1) && (wr_rdy === 1'b1);
    last_rd_fire = rd_f;
    if (rd_rsp_val === 1'b1) rsp_seen = 1'b1;
    if (rsp_f) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: got data %h tag %h, required no response", rd_rsp_data, rd_rsp_tag);
      end else begin
        e = sb.pop_front();
        if (rd_rsp_data !== e.data || rd_rsp_tag !== e.tag) begin
          n_fail++;
          $display("FAIL rsp_data: got data %h tag %h, required data %h tag %h",
                   rd_rsp_data, rd_rsp_tag, e.data, e.tag);
        end
        if (chk_lat) begin
          n_tests++;
          if (cyc - e.cyc != int'(LAT)) begin
            n_fail++;
            $display("FAIL rsp_latency: got %0d cycles, required %0d", cyc - e.cyc, LAT);
          end
        end
      end
    end
    if (reset === 1'b1) begin
      if (rd_f) begin
        rexp = model[rd_req_addr];
        if (RDW_NEW != 0 && wr_f && wr_addr == rd_req_addr) rexp = merge(rexp, wr_data, wr_byte_en);
        e.data = rexp;
        e.tag  = rd_req_tag;
        e.cyc  = cyc;
        sb.push_back(e);
      end
      if (wr_f) model[wr_addr] = merge(model[wr_addr], wr_data, wr_byte_en);
    end else begin
      sb.delete();
    end
    n_tests++;
    if (sb.size() > int'(LAT)) begin
      n_fail++;
      $display("FAIL occupancy: got %0d outstanding reads, required at most %0d", sb.size(), LAT);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    rd_req_val = 1'b0;
    wr_val     = 1'b0;
  endtask

  task automatic drain(input int limit);
    idle();
    rd_rsp_rdy = 1'b1;
    for (int i = 0; i < limit && sb.size() > 0; i++) step();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d responses pending, required 0", sb.size());
    end
  endtask

  task automatic rd_issue(input logic [AW-1:0] a, input logic [TW-1:0] t);
    bit fired;
    fired       = 1'b0;
    rd_req_val  = 1'b1;
    rd_req_addr = a;
    rd_req_tag  = t;
    for (int i = 0; i < 50 && !fired; i++) begin
      step();
      fired = last_rd_fire;
    end
    rd_req_val = 1'b0;
    n_tests++;
    if (!fired) begin
      n_fail++;
      $display("FAIL rd_issue_timeout: got no request fire, required fire for addr %0d", a);
    end
  endtask

  task automatic wr_issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    wr_val     = 1'b1;
    wr_addr    = a;
    wr_data    = d;
    wr_byte_en = be;
    step();
    wr_val = 1'b0;
  endtask

  task automatic test_reset();
    int low;
    reset = 1'b0;
    idle();
    rd_rsp_rdy = 1'b1;
    step();
    step();
    #1;
    n_tests += 3;
    if (rd_rsp_val !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_val: got %b, required 0", rd_rsp_val); end
    if (rd_req_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rd_rdy: got %b, required 0", rd_req_rdy); end
    if (wr_rdy !== 1'b0)     begin n_fail++; $display("FAIL reset_wr_rdy: got %b, required 0", wr_rdy); end
    reset = 1'b1;
    #1;
    n_tests++;
    if (rd_req_rdy !== 1'b0) begin n_fail++; $display("FAIL rdy_release_cycle: got %b, required 0", rd_req_rdy); end
    low = 0;
    for (int i = 0; i < 100; i++) begin
      if (wr_rdy === 1'b1) break;
      low++;
      step();
    end
`ifdef VC_SRAM_CLEAR_EN
    n_tests++;
    if (low != int'(NE)) begin n_fail++; $display("FAIL clear_cycles: got %0d, required %0d", low, NE); end
    for (int i = 0; i < NE; i++) model[i] = '0;
`else
    n_tests++;
    if (low != 1) begin n_fail++; $display("FAIL rdy_rise: got %0d low cycles, required 1", low); end
`endif
    #1;
    n_tests++;
    if (rd_req_rdy !== 1'b1) begin n_fail++; $display("FAIL rd_rdy_after_reset: got %b, required 1", rd_req_rdy); end
  endtask

`ifdef VC_SRAM_CLEAR_EN
  task automatic test_clear();
    for (int i = 0; i < NE; i += 5) rd_issue(AW'(i), TW'(i));
    drain(30);
  endtask
`endif

  task automatic test_init();
    for (int i = 0; i < NE; i++)
      wr_issue(AW'(i), {8'(i), 8'hA5, 8'(i * 3), 8'h5A}, 4'hF);
  endtask

  task automatic test_write_read();
    wr_issue(4'd5, 32'hDEADBEEF, 4'hF);
    chk_lat = 1'b1;
    rd_issue(4'd5, 4'd3);
    drain(20);
    chk_lat = 1'b0;
  endtask

  task automatic test_rdw();
    rd_req_val  = 1'b1;
    rd_req_addr = 4'd5;
    rd_req_tag  = 4'd7;
    wr_val      = 1'b1;
    wr_addr     = 4'd5;
    wr_data     = 32'h11223344;
    wr_byte_en  = 4'b0101;
    step();
    n_tests++;
    if (!last_rd_fire) begin n_fail++; $display("FAIL rdw_fire: got no read fire, required fire"); end
    idle();
    drain(20);
    rd_issue(4'd5, 4'd8);
    drain(20);
  endtask

  task automatic test_back_to_back();
    int acc;
    acc        = 0;
    rd_rsp_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_req_val  = 1'b1;
      rd_req_addr = AW'(acc);
      rd_req_tag  = TW'(acc);
      step();
      if (last_rd_fire) acc++;
    end
    #1;
    n_tests += 2;
    if (acc != int'(LAT)) begin n_fail++; $display("FAIL b2b_accepted: got %0d, required %0d", acc, LAT); end
    if (rd_req_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy: got %b, required 0", rd_req_rdy); end
    rd_rsp_rdy = 1'b1;
    for (int i = 0; i < 100 && acc < 8; i++) begin
      rd_req_val  = 1'b1;
      rd_req_addr = AW'(acc);
      rd_req_tag  = TW'(acc);
      step();
      if (last_rd_fire) acc++;
    end
    drain(20);
    n_tests++;
    if (acc != 8) begin n_fail++; $display("FAIL b2b_total: got %0d, required 8", acc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      rd_req_val  = 1'($urandom_range(0, 1));
      rd_req_addr = AW'($urandom_range(0, NE - 1));
      rd_req_tag  = TW'($urandom);
      wr_val      = 1'($urandom_range(0, 1));
      wr_addr     = AW'($urandom_range(0, NE - 1));
      wr_byte_en  = NB'($urandom);
      wr_data     = DW'($urandom);
      rd_rsp_rdy  = 1'($urandom_range(0, 1));
      step();
    end
    drain(50);
  endtask

  task automatic test_reset_inflight();
    logic [DW-1:0] old9;
    old9       = model[9];
    rd_rsp_rdy = 1'b1;
    rd_issue(4'd1, 4'd1);
    rd_issue(4'd2, 4'd2);
    reset      = 1'b0;
    wr_val     = 1'b1;
    wr_addr    = 4'd9;
    wr_data    = 32'hBADC0FFE;
    wr_byte_en = 4'hF;
    step();
    reset = 1'b1;
    idle();
    #1;
    n_tests++;
    if (rd_rsp_val !== 1'b0) begin n_fail++; $display("FAIL reset_flush_val: got %b, required 0", rd_rsp_val); end
    rsp_seen = 1'b0;
    for (int i = 0; i < 10; i++) step();
    n_tests++;
    if (rsp_seen) begin n_fail++; $display("FAIL reset_stale_rsp: got a response, required none"); end
    rd_issue(4'd9, 4'd9);
    drain(20);
    n_tests++;
    if (model[9] !== old9) begin n_fail++; $display("FAIL reset_write_drop_model: got %h, required %h", model[9], old9); end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    cyc         = 0;
    chk_lat     = 1'b0;
    rsp_seen    = 1'b0;
    reset       = 1'b0;
    rd_req_val  = 1'b0;
    rd_req_addr = '0;
    rd_req_tag  = '0;
    rd_rsp_rdy  = 1'b1;
    wr_val      = 1'b0;
    wr_addr     = '0;
    wr_byte_en  = '0;
    wr_data     = '0;
    @(negedge clk);
    test_reset();
`ifdef VC_SRAM_CLEAR_EN
    test_clear();
`endif
    test_init();
    test_write_read();
    test_rdw();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
